// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - registered ALU with iterative multiply/divide unit
module alu_mdu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      ALU_OP_i,
    input  logic [XLEN-1:0] ALU_RS1_i,
    input  logic [XLEN-1:0] ALU_RS2_i,
    output logic            valid_o,
    output logic [XLEN-1:0] ALU_RD_o,
    output logic            ALU_ZR_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SHW-1:0]    counter_q;
    logic [2*XLEN-1:0] acc_q;       // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
    logic [XLEN-1:0]   opb_q;       // multiplicand / divisor magnitude
    logic [XLEN-1:0]   a_raw_q;     // raw dividend, returned by REM on divide-by-zero
    logic              neg_a_q;
    logic              neg_b_q;
    logic [1:0]        sub_op_q;
    logic [XLEN-1:0]   rd_q;
    logic              valid_q;

    logic accept;
    logic is_mdu;
    logic last_iter;

    assign ready_o   = (state_q == S_IDLE);
    assign accept    = valid_i && ready_o;
    assign is_mdu    = ALU_OP_i[4] && !ALU_OP_i[3];
    assign last_iter = (counter_q == SHW'(XLEN - 1));
    assign valid_o   = valid_q;
    assign ALU_RD_o  = rd_q;
    assign ALU_ZR_o  = (rd_q == '0);

    // Single-cycle base ALU result; 1xxxx codes outside the M range fall out as 0
    logic [XLEN-1:0] base_res;
    logic [SHW-1:0]  shamt;
    assign shamt = ALU_RS2_i[SHW-1:0];

    always_comb begin
        base_res = '0;
        if (!ALU_OP_i[4]) begin
            case (ALU_OP_i[3:0])
                4'b0000: base_res = ALU_RS1_i & ALU_RS2_i;
                4'b0001: base_res = ALU_RS1_i | ALU_RS2_i;
                4'b0010: base_res = ALU_RS1_i + ALU_RS2_i;
                4'b0011: base_res = XLEN'(ALU_RS1_i == ALU_RS2_i);
                4'b0100: base_res = ALU_RS1_i << shamt;
                4'b0101: base_res = ALU_RS1_i >> shamt;
                4'b0111: base_res = XLEN'($signed(ALU_RS1_i) >>> shamt);
                4'b1000: base_res = ALU_RS1_i ^ ALU_RS2_i;
                4'b1001: base_res = ~(ALU_RS1_i | ALU_RS2_i);
                4'b1010: base_res = ALU_RS1_i - ALU_RS2_i;
                4'b1100: base_res = XLEN'($signed(ALU_RS1_i) >= $signed(ALU_RS2_i));
                4'b1101: base_res = XLEN'(ALU_RS1_i >= ALU_RS2_i);
                4'b1110: base_res = XLEN'($signed(ALU_RS1_i) < $signed(ALU_RS2_i));
                4'b1111: base_res = XLEN'(ALU_RS1_i < ALU_RS2_i);
                default: base_res = '0;
            endcase
        end
    end

    // Operand signedness and magnitudes for the iterative unit
    logic            signed_a, signed_b;
    logic            neg_a_in, neg_b_in;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        if (ALU_OP_i[2]) begin
            signed_a = !ALU_OP_i[0];
            signed_b = !ALU_OP_i[0];
        end else begin
            signed_a = (ALU_OP_i[1:0] == 2'b01) || (ALU_OP_i[1:0] == 2'b10);
            signed_b = (ALU_OP_i[1:0] == 2'b01);
        end
        neg_a_in = signed_a && ALU_RS1_i[XLEN-1];
        neg_b_in = signed_b && ALU_RS2_i[XLEN-1];
        a_mag    = neg_a_in ? -ALU_RS1_i : ALU_RS1_i;
        b_mag    = neg_b_in ? -ALU_RS2_i : ALU_RS2_i;
    end

    // One shift-add or restoring-subtract step on the accumulator
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     div_rsh;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] acc_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        div_rsh  = acc_q[2*XLEN-1:XLEN-1];
        div_ge   = (div_rsh >= {1'b0, opb_q});
        div_diff = div_rsh - {1'b0, opb_q};
        div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_rsh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        acc_nxt  = (state_q == S_DIV) ? div_nxt : mul_nxt;
    end

    // Sign fix-up and special cases applied to the final iteration's value
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   mdu_res;

    always_comb begin
        prod_s  = (neg_a_q ^ neg_b_q) ? -mul_nxt : mul_nxt;
        quot    = div_nxt[XLEN-1:0];
        rem     = div_nxt[2*XLEN-1:XLEN];
        mdu_res = '0;
        if (state_q == S_MUL) begin
            mdu_res = (sub_op_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (opb_q == '0) begin
            mdu_res = sub_op_q[1] ? a_raw_q : '1;
        end else if (sub_op_q[1]) begin
            mdu_res = neg_a_q ? -rem : rem;
        end else begin
            mdu_res = (neg_a_q ^ neg_b_q) ? -quot : quot;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter MUL/DIV on an accepted M op, leave after the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mdu) begin
                    state_d = ALU_OP_i[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and result/valid registration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            a_raw_q   <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            sub_op_q  <= 2'b00;
            rd_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (accept) begin
                    if (is_mdu) begin
                        counter_q <= '0;
                        acc_q     <= {{XLEN{1'b0}}, a_mag};
                        opb_q     <= b_mag;
                        a_raw_q   <= ALU_RS1_i;
                        neg_a_q   <= neg_a_in;
                        neg_b_q   <= neg_b_in;
                        sub_op_q  <= ALU_OP_i[1:0];
                    end else begin
                        rd_q    <= base_res;
                        valid_q <= 1'b1;
                    end
                end
            end else begin
                acc_q     <= acc_nxt;
                counter_q <= counter_q + 1'b1;
                if (last_iter) begin
                    counter_q <= '0;
                    rd_q      <= mdu_res;
                    valid_q   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - randomized self-checking bench for alu_mdu_seq
module tb_alu_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  op_i;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        valid_o;
    logic [31:0] rd;
    logic        zr;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mdu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALU_OP_i  (op_i),
        .ALU_RS1_i (rs1),
        .ALU_RS2_i (rs2),
        .valid_o   (valid_o),
        .ALU_RD_o  (rd),
        .ALU_ZR_o  (zr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V base/M semantics with 64-bit host arithmetic
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int              ia;
        int              ib;
        longint          sp;
        longint unsigned up;
        logic [31:0]     r;
        ia = a;
        ib = b;
        r  = '0;
        case (op)
            5'd0:  r = a & b;
            5'd1:  r = a | b;
            5'd2:  r = a + b;
            5'd3:  r = {31'b0, a == b};
            5'd4:  r = a << b[4:0];
            5'd5:  r = a >> b[4:0];
            5'd7:  r = ia >>> b[4:0];
            5'd8:  r = a ^ b;
            5'd9:  r = ~(a | b);
            5'd10: r = a - b;
            5'd12: r = {31'b0, ia >= ib};
            5'd13: r = {31'b0, a >= b};
            5'd14: r = {31'b0, ia < ib};
            5'd15: r = {31'b0, a < b};
            5'd16: begin up = longint'(a) * longint'(b); r = up[31:0]; end
            5'd17: begin sp = longint'(ia) * longint'(ib); r = sp[63:32]; end
            5'd18: begin sp = longint'(ia) * longint'({32'b0, b}); r = sp[63:32]; end
            5'd19: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); r = up[63:32]; end
            5'd20: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = ia / ib;
            end
            5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = ia % ib;
            end
            5'd23: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [4:0] op);
        return (op[4] && !op[3]) ? 33 : 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, then count edges (accept edge = 1) until valid_o
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        valid_i = 1'b1;
        op_i    = op;
        rs1     = a;
        rs2     = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        op_i    = 5'($urandom);
        rs1     = $urandom;
        rs2     = $urandom;
        lat     = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = rd;
        z   = zr;
    endtask

    task automatic run_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        logic        z;
        int          lat;
        run_op(op, a, b, res, z, lat);
        check({tag, "_rd"}, res, exp);
        check({tag, "_zr"}, z, exp == 0);
        check({tag, "_lat"}, lat, exp_latency(op));
    endtask

    initial begin
        logic [4:0]  bb_op  [3];
        logic [31:0] bb_a   [3];
        logic [31:0] bb_b   [3];
        logic [31:0] bb_exp [3];
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        int          n;
        int          bad;
        int          pulses;

        rst_n   = 1'b0;
        valid_i = 1'b0;
        op_i    = '0;
        rs1     = '0;
        rs2     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", rd, 32'h0);
        check("rst_zr", zr, 1'b1);
        check("rst_valid", valid_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back base ops
        bb_op  = '{5'b01010, 5'b00111, 5'b01111};
        bb_a   = '{32'd5, 32'h8000_0000, 32'd1};
        bb_b   = '{32'd7, 32'd4, 32'hFFFF_FFFF};
        bb_exp = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1};
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = bb_op[0];
        rs1     = bb_a[0];
        rs2     = bb_b[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_valid", i), valid_o, 1'b1);
            check($sformatf("b2b%0d_rd", i), rd, bb_exp[i]);
            check($sformatf("b2b%0d_zr", i), zr, 1'b0);
            check($sformatf("b2b%0d_ready", i), ready_o, 1'b1);
            check($sformatf("b2b%0d_model", i), rd, model(bb_op[i], bb_a[i], bb_b[i]));
            if (i < 2) begin
                op_i = bb_op[i+1];
                rs1  = bb_a[i+1];
                rs2  = bb_b[i+1];
            end else begin
                valid_i = 1'b0;
            end
        end

        // Directed mul/div and undefined codes
        run_check("mulh_ff", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        run_check("mul_ovf", 5'b10000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        run_check("div_m7_2", 5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_check("rem_m7_2", 5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_check("divu_z", 5'b10101, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_check("remu_z", 5'b10111, 32'd100, 32'd0, 32'd100);
        run_check("div_ovf", 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_check("rem_ovf", 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_check("undef_0110", 5'b00110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        run_check("undef_11001", 5'b11001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);

        // Reset in the middle of a MUL aborts it
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = 5'b10000;
        rs1     = 32'd12345;
        rs2     = 32'd678;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", valid_o, 1'b0);
        check("midrst_ready", ready_o, 1'b1);
        check("midrst_rd", rd, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_o) pulses++;
        end
        check("midrst_no_pulse", pulses, 0);

        // Held request waits while DIVU is busy, accepted on its valid_o cycle
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = 5'b10101;
        rs1     = 32'd1000;
        rs2     = 32'd7;
        @(posedge clk);
        #1;
        op_i = 5'b00010;
        rs1  = 32'd3;
        rs2  = 32'd4;
        n    = 1;
        bad  = 0;
        while (!valid_o && n < 100) begin
            if (ready_o) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        check("hs_busy_ready", bad, 0);
        check("hs_divu_lat", n, 33);
        check("hs_divu_rd", rd, 32'd142);
        check("hs_ready_at_done", ready_o, 1'b1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        check("hs_sum_valid", valid_o, 1'b1);
        check("hs_sum_rd", rd, 32'd7);

        // Randomized ops against the reference model
        for (int i = 0; i < 80; i++) begin
            logic [31:0] res;
            logic        z;
            int          lat;
            op = 5'($urandom_range(0, 31));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, res, z, lat);
            check($sformatf("rnd%0d_op%0d_rd", i, op), res, model(op, a, b));
            check($sformatf("rnd%0d_zr", i), z, model(op, a, b) == 0);
            check($sformatf("rnd%0d_lat", i), lat, exp_latency(op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
